// File: rtl/arm7_memctl_if.sv
// ARM7 system bus signal bundle shared by the core (master) and the
// memory controller (slave).
interface arm7_memctl_if;
    logic        nMREQ;
    logic        SEQ;
    logic        nRW;
    logic [1:0]  MAS;
    logic [31:0] A;
    logic [31:0] D_in;
    logic [31:0] D_out;
    logic        nWAIT;
    logic        ABORT;

    modport master (
        output nMREQ, SEQ, nRW, MAS, A, D_in,
        input  D_out, nWAIT, ABORT
    );

    modport slave (
        input  nMREQ, SEQ, nRW, MAS, A, D_in,
        output D_out, nWAIT, ABORT
    );
endinterface

// File: rtl/arm7_memctl.sv
// ARM7 memory controller: word-organised on-chip RAM with separate
// nonsequential/sequential wait counts, byte/halfword/word write lanes,
// selectable endianness, abort on illegal accesses and a same-edge
// read-after-write bypass for pipelined accesses.
module arm7_memctl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int N_WAIT     = 2,
    parameter int S_WAIT     = 0,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic          sysclk,
    input logic          RESET,
    arm7_memctl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LAST
    } stateT;

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [1:0] BYTE_FLIP = BIG_ENDIAN ? 2'b11 : 2'b00;
    localparam logic [1:0] HALF_FLIP = BIG_ENDIAN ? 2'b10 : 2'b00;

    stateT                 state;
    stateT                 stateNext;
    logic [3:0]            counter;
    logic [3:0]            counterNext;

    logic [DEPTH_LOG2-1:0] wordReg;
    logic [1:0]            byteReg;
    logic [1:0]            masReg;
    logic                  writeReg;
    logic                  abortReg;
    logic [31:0]           doutReg;
    logic                  abortOut;

    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic [3:0]            waitCount;
    logic                  reqAbort;
    logic [DEPTH_LOG2-1:0] reqWord;
    logic [1:0]            byteLane;
    logic [1:0]            halfLane;
    logic [31:0]           laneMask;
    logic                  commit;
    logic [31:0]           mergedWord;
    logic                  enterLast;
    logic                  enterAbort;
    logic                  enterRead;
    logic [DEPTH_LOG2-1:0] readWord;
    logic [31:0]           readData;

    assign bus.nWAIT = (state != WAIT);
    assign bus.D_out = doutReg;
    assign bus.ABORT = abortOut;

    assign accept    = !bus.nMREQ && (state != WAIT);
    assign waitCount = bus.SEQ ? 4'(S_WAIT) : 4'(N_WAIT);
    assign reqWord   = bus.A[DEPTH_LOG2+1:2];

    // Classify the request on the bus as legal or aborted
    always_comb begin
        reqAbort = 1'b0;
        if ((bus.A >> (DEPTH_LOG2 + 2)) != 32'd0) begin
            reqAbort = 1'b1;
        end
        case (bus.MAS)
            2'b00:   ;
            2'b01:   if (bus.A[0]) reqAbort = 1'b1;
            2'b10:   if (bus.A[1:0] != 2'b00) reqAbort = 1'b1;
            default: reqAbort = 1'b1;
        endcase
    end

    // Next-state and wait-counter logic
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        case (state)
            IDLE, LAST: begin
                if (accept) begin
                    if (waitCount != 4'd0) begin
                        stateNext   = WAIT;
                        counterNext = waitCount;
                    end else begin
                        stateNext   = LAST;
                        counterNext = 4'd0;
                    end
                end else begin
                    stateNext   = IDLE;
                    counterNext = 4'd0;
                end
            end
            WAIT: begin
                counterNext = counter - 4'd1;
                if (counter == 4'd1) begin
                    stateNext = LAST;
                end
            end
            default: begin
                stateNext   = IDLE;
                counterNext = 4'd0;
            end
        endcase
    end

    // Byte-enable mask of the registered write, in D_in lane positions
    always_comb begin
        byteLane = byteReg ^ BYTE_FLIP;
        halfLane = {byteReg[1], 1'b0} ^ HALF_FLIP;
        case (masReg)
            2'b00:   laneMask = 32'h0000_00FF << {byteLane, 3'b000};
            2'b01:   laneMask = 32'h0000_FFFF << {halfLane, 3'b000};
            default: laneMask = 32'hFFFF_FFFF;
        endcase
    end

    assign commit     = (state == LAST) && writeReg && !abortReg && !RESET;
    assign mergedWord = (bus.D_in & laneMask) | (mem[wordReg] & ~laneMask);

    // Which access is about to enter LAST, and where its read data comes from
    always_comb begin
        enterLast  = (stateNext == LAST);
        enterAbort = (state == WAIT) ? abortReg : reqAbort;
        enterRead  = (state == WAIT) ? !writeReg : !bus.nRW;
        readWord   = (state == WAIT) ? wordReg : reqWord;
        if (commit && (wordReg == readWord)) begin
            readData = mergedWord;
        end else begin
            readData = mem[readWord];
        end
    end

    // State, captured request and registered outputs
    always_ff @(posedge sysclk) begin
        if (RESET) begin
            state    <= IDLE;
            counter  <= 4'd0;
            wordReg  <= '0;
            byteReg  <= 2'b00;
            masReg   <= 2'b00;
            writeReg <= 1'b0;
            abortReg <= 1'b0;
            doutReg  <= 32'd0;
            abortOut <= 1'b0;
        end else begin
            state    <= stateNext;
            counter  <= counterNext;
            abortOut <= enterLast && enterAbort;
            if (accept) begin
                wordReg  <= reqWord;
                byteReg  <= bus.A[1:0];
                masReg   <= bus.MAS;
                writeReg <= bus.nRW;
                abortReg <= reqAbort;
            end
            if (enterLast && enterRead) begin
                doutReg <= enterAbort ? 32'd0 : readData;
            end
        end
    end

    // RAM write port; contents are deliberately left alone by reset
    always_ff @(posedge sysclk) begin
        if (commit) begin
            mem[wordReg] <= mergedWord;
        end
    end
endmodule

// File: tb/tb_arm7_memctl.sv
// Randomised self-checking bench for arm7_memctl: a little-endian and a
// big-endian instance share one stimulus stream and are checked against a
// byte-lane reference model of the memory.
module tb_arm7_memctl;
    localparam int DEPTH_LOG2 = 10;
    localparam int N_WAIT     = 2;
    localparam int S_WAIT     = 0;

    logic        sysclk = 1'b0;
    logic        RESET;
    logic        nMREQ;
    logic        SEQ;
    logic        nRW;
    logic [1:0]  MAS;
    logic [31:0] A;
    logic [31:0] D_in;

    int          assertCount = 0;
    int          failCount   = 0;

    logic [31:0] modelMem [2][64];
    logic [31:0] lastDout [2];

    arm7_memctl_if busLe ();
    arm7_memctl_if busBe ();

    assign busLe.nMREQ = nMREQ;
    assign busLe.SEQ   = SEQ;
    assign busLe.nRW   = nRW;
    assign busLe.MAS   = MAS;
    assign busLe.A     = A;
    assign busLe.D_in  = D_in;
    assign busBe.nMREQ = nMREQ;
    assign busBe.SEQ   = SEQ;
    assign busBe.nRW   = nRW;
    assign busBe.MAS   = MAS;
    assign busBe.A     = A;
    assign busBe.D_in  = D_in;

    arm7_memctl #(
        .DEPTH_LOG2(DEPTH_LOG2), .N_WAIT(N_WAIT), .S_WAIT(S_WAIT), .BIG_ENDIAN(1'b0)
    ) dutLe (
        .sysclk(sysclk), .RESET(RESET), .bus(busLe)
    );

    arm7_memctl #(
        .DEPTH_LOG2(DEPTH_LOG2), .N_WAIT(N_WAIT), .S_WAIT(S_WAIT), .BIG_ENDIAN(1'b1)
    ) dutBe (
        .sysclk(sysclk), .RESET(RESET), .bus(busBe)
    );

    // Free-running system clock
    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit isAbort(input logic [1:0] mas, input logic [31:0] addr);
        if (addr >= (32'd4 << DEPTH_LOG2)) return 1'b1;
        if (mas == 2'd3) return 1'b1;
        if (mas == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (mas == 2'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // The access covers address-order bytes; byte offset o sits in lane o
    // (little-endian) or lane 3-o (big-endian) and takes D_in from that lane.
    function automatic logic [31:0] modelMerge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [1:0] mas, input logic [31:0] addr,
                                               input int bigEnd);
        logic [31:0] result;
        int          nBytes;
        int          base;
        int          lane;
        result = old;
        nBytes = (mas == 2'd0) ? 1 : (mas == 2'd1) ? 2 : 4;
        base   = int'(addr % 4) - int'(addr % 4) % nBytes;
        for (int k = 0; k < nBytes; k++) begin
            lane = (bigEnd != 0) ? 3 - (base + k) : base + k;
            result[8*lane +: 8] = data[8*lane +: 8];
        end
        return result;
    endfunction

    task automatic applyStimulus(input bit seq, input bit write, input logic [1:0] mas,
                                 input logic [31:0] addr, input logic [31:0] data);
        int  w;
        bit  abt;
        int  idx;
        w   = seq ? S_WAIT : N_WAIT;
        abt = isAbort(mas, addr);
        idx = int'(addr[7:2]);
        nMREQ = 1'b0;
        SEQ   = seq;
        nRW   = write;
        MAS   = mas;
        A     = addr;
        @(posedge sysclk);
        #1;
        D_in  = write ? data : $urandom();
        nMREQ = 1'($urandom_range(0, 1));
        for (int i = 0; i < w; i++) begin
            @(negedge sysclk);
            checkOutput("waitLe", {31'd0, busLe.nWAIT}, 32'd0);
            checkOutput("waitBe", {31'd0, busBe.nWAIT}, 32'd0);
            checkOutput("holdLe", busLe.D_out, lastDout[0]);
            checkOutput("holdBe", busBe.D_out, lastDout[1]);
        end
        @(negedge sysclk);
        for (int e = 0; e < 2; e++) begin
            if (!write) lastDout[e] = abt ? 32'd0 : modelMem[e][idx];
        end
        checkOutput("lastNwaitLe", {31'd0, busLe.nWAIT}, 32'd1);
        checkOutput("lastNwaitBe", {31'd0, busBe.nWAIT}, 32'd1);
        checkOutput("abortLe", {31'd0, busLe.ABORT}, {31'd0, abt});
        checkOutput("abortBe", {31'd0, busBe.ABORT}, {31'd0, abt});
        checkOutput("doutLe", busLe.D_out, lastDout[0]);
        checkOutput("doutBe", busBe.D_out, lastDout[1]);
        if (write && !abt) begin
            for (int e = 0; e < 2; e++) begin
                modelMem[e][idx] = modelMerge(modelMem[e][idx], data, mas, addr, e);
            end
        end
    endtask

    task automatic idleCycle();
        nMREQ = 1'b1;
        SEQ   = 1'($urandom_range(0, 1));
        A     = $urandom();
        @(negedge sysclk);
        checkOutput("idleNwaitLe", {31'd0, busLe.nWAIT}, 32'd1);
        checkOutput("idleAbortLe", {31'd0, busLe.ABORT}, 32'd0);
        checkOutput("idleDoutLe", busLe.D_out, lastDout[0]);
        checkOutput("idleDoutBe", busBe.D_out, lastDout[1]);
    endtask

    initial begin
        bit          seq;
        bit          wr;
        logic [1:0]  mas;
        logic [31:0] addr;
        int          kind;

        RESET = 1'b1;
        nMREQ = 1'b1;
        SEQ   = 1'b0;
        nRW   = 1'b0;
        MAS   = 2'b10;
        A     = 32'd0;
        D_in  = 32'd0;
        lastDout[0] = 32'd0;
        lastDout[1] = 32'd0;
        repeat (3) @(negedge sysclk);
        checkOutput("rstNwait", {31'd0, busLe.nWAIT}, 32'd1);
        checkOutput("rstAbort", {31'd0, busLe.ABORT}, 32'd0);
        checkOutput("rstDoutLe", busLe.D_out, 32'd0);
        checkOutput("rstDoutBe", busBe.D_out, 32'd0);
        RESET = 1'b0;
        @(negedge sysclk);

        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'(i % 2), 1'b1, 2'b10, 32'(i * 4), $urandom());
        end
        idleCycle();

        applyStimulus(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h10, 32'd0);
        checkOutput("wordReadLe", busLe.D_out, 32'hDEAD_BEEF);
        checkOutput("wordReadBe", busBe.D_out, 32'hDEAD_BEEF);
        idleCycle();

        applyStimulus(1'b0, 1'b1, 2'b10, 32'h20, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h21, 32'hAAAA_AAAA);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h22, 32'h1234_1234);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h20, 32'd0);
        checkOutput("lanesLe", busLe.D_out, 32'h1234_AA00);
        checkOutput("lanesBe", busBe.D_out, 32'h00AA_1234);
        idleCycle();

        applyStimulus(1'b0, 1'b0, 2'b10, 32'h3C, 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h40, 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h44, 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h48, 32'd0);
        idleCycle();

        applyStimulus(1'b1, 1'b1, 2'b10, 32'h80, 32'h55AA_55AA);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h80, 32'd0);
        checkOutput("bypassLe", busLe.D_out, 32'h55AA_55AA);
        checkOutput("bypassBe", busBe.D_out, 32'h55AA_55AA);
        idleCycle();

        applyStimulus(1'b0, 1'b1, 2'b10, 32'h1000, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, 2'b01, 32'h03, 32'd0);
        checkOutput("abortHalfDout", busLe.D_out, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'b11, 32'h04, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h08, 32'd0);
        checkOutput("abortMasDout", busLe.D_out, 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h00, 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h04, 32'd0);
        idleCycle();

        applyStimulus(1'b0, 1'b1, 2'b10, 32'h30, 32'h1111_1111);
        idleCycle();
        nMREQ = 1'b0;
        SEQ   = 1'b0;
        nRW   = 1'b1;
        MAS   = 2'b10;
        A     = 32'h30;
        @(posedge sysclk);
        #1;
        D_in  = 32'h2222_2222;
        nMREQ = 1'b1;
        @(posedge sysclk);
        #1;
        checkOutput("rstMidWaitNwait", {31'd0, busLe.nWAIT}, 32'd0);
        RESET = 1'b1;
        @(posedge sysclk);
        #1;
        RESET = 1'b0;
        @(negedge sysclk);
        checkOutput("rstMidNwait", {31'd0, busLe.nWAIT}, 32'd1);
        checkOutput("rstMidAbort", {31'd0, busLe.ABORT}, 32'd0);
        checkOutput("rstMidDoutLe", busLe.D_out, 32'd0);
        checkOutput("rstMidDoutBe", busBe.D_out, 32'd0);
        lastDout[0] = 32'd0;
        lastDout[1] = 32'd0;
        idleCycle();
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h30, 32'd0);
        checkOutput("rstMidKeptLe", busLe.D_out, 32'h1111_1111);
        checkOutput("rstMidKeptBe", busBe.D_out, 32'h1111_1111);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                idleCycle();
            end else begin
                seq  = 1'($urandom_range(0, 1));
                wr   = 1'($urandom_range(0, 1));
                mas  = 2'($urandom_range(0, 2));
                addr = 32'($urandom_range(0, 255));
                if (kind == 1) begin
                    mas = 2'($urandom_range(0, 3));
                end else begin
                    if (mas == 2'd1) addr[0] = 1'b0;
                    if (mas == 2'd2) addr[1:0] = 2'b00;
                end
                if (kind == 2) begin
                    addr = addr | (32'd1 << $urandom_range(12, 31));
                end
                applyStimulus(seq, wr, mas, addr, $urandom());
            end
        end
        idleCycle();
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
